// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder_pkg
//  Description : Shared constants and layout helpers for the pipelined
//                carry-lookahead adder/subtractor.
//
//                The operand and partial-sum pipeline registers are packed
//                as triangular flat vectors so that every level holds only
//                the bits it still needs:
//                  - operand level k (k = 0..NBLK-1) holds WIDTH-4k bits of
//                    the not-yet-added operand bits;
//                  - sum level k (k = 1..NBLK) holds the 4k result bits
//                    already produced.
//                The functions below give the slice offsets and totals.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pipe_adder_pkg;

    // Bits handled by one lookahead block (and therefore by one stage).
    localparam int c_BLK_W = 4;

    // Number of lookahead blocks, which is also the pipeline depth.
    function automatic int nblk_of(input int width);
        return width / c_BLK_W;
    endfunction

    // Offset of operand level k inside the flat operand vector:
    // sum over j<k of (width - 4j).
    function automatic int opnd_off(input int width, input int k);
        return k * width - (c_BLK_W * k * (k - 1)) / 2;
    endfunction

    // Total bits of the flat operand vector (levels 0..NBLK-1).
    function automatic int opnd_total(input int width);
        return opnd_off(width, nblk_of(width));
    endfunction

    // Offset of sum level k (k >= 1): sum over j<k of 4j.
    function automatic int sum_off(input int k);
        return (c_BLK_W * k * (k - 1)) / 2;
    endfunction

    // Total bits of the flat sum vector (levels 1..nblk).
    function automatic int sum_total(input int nblk);
        return sum_off(nblk + 1);
    endfunction

endpackage : cla_pipe_adder_pkg
`default_nettype wire

// File: rtl/cla_pipe_adder_block.sv
`default_nettype none
// ============================================================================
//  Module      : cla_block
//  Description : Combinational 4-bit carry-lookahead adder slice. All four
//                internal carries are formed directly from generate and
//                propagate terms, with no ripple between bit positions.
//  Ports       : a, b  - 4-bit operands (b already inverted for subtract)
//                ci    - carry into bit 0
//                s     - 4-bit sum
//                co    - carry out of bit 3
//                c3    - carry into bit 3 (used for signed overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic       w_c1;
    logic       w_c2;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c1 = w_g[0] | (w_p[0] & ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ {c3, w_c2, w_c1, ci};

endmodule : cla_block
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined WIDTH-bit carry-lookahead adder/subtractor. One
//                4-bit lookahead block is evaluated per stage, the
//                inter-block carry travels in registers. Valid/ready on
//                both sides; the whole pipe shifts or holds as one.
//                WIDTH must be a multiple of 4 and at least 4.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid/in_ready  - input handshake
//                A, B, Cin, sub     - operands, carry-in, 1 = A-B
//                out_valid/out_ready- output handshake
//                sum, cout, ovf     - result, carry out, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK     = nblk_of(WIDTH);
    localparam int c_OPND_W = opnd_total(WIDTH);
    localparam int c_SUM_W  = sum_total(NBLK);

    // Register levels: level 0 captures the (pre-processed) operands,
    // level k+1 holds the result of block k. Level NBLK drives the outputs,
    // so an operand accepted at edge T is visible after edge T+NBLK.
    logic [NBLK:0]         r_v;
    logic [NBLK:0]         r_c;      // r_c[k]: carry into block k; r_c[NBLK]: cout
    logic [c_OPND_W-1:0]   r_a;
    logic [c_OPND_W-1:0]   r_b;
    logic [c_SUM_W-1:0]    r_sum;
    logic                  r_ovf;

    logic [NBLK:0]         w_c_nxt;
    logic [c_OPND_W-1:0]   w_a_nxt;
    logic [c_OPND_W-1:0]   w_b_nxt;
    logic [c_SUM_W-1:0]    w_sum_nxt;
    logic                  w_ovf_nxt;
    logic                  w_adv;

    // The pipe moves only when the output slot is empty or being drained.
    assign w_adv    = !r_v[NBLK] || out_ready;
    assign in_ready = w_adv;

    // Subtraction is A + ~B + 1; Cin has no effect in that mode.
    assign w_a_nxt[WIDTH-1:0] = A;
    assign w_b_nxt[WIDTH-1:0] = sub ? ~B : B;
    assign w_c_nxt[0]         = sub | Cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int c_AO = opnd_off(WIDTH, k);
        localparam int c_AW = WIDTH - c_BLK_W * k;

        logic [3:0] w_s;
        logic       w_co;
        logic       w_c3;

        cla_block u_blk (
            .a  (r_a[c_AO +: c_BLK_W]),
            .b  (r_b[c_AO +: c_BLK_W]),
            .ci (r_c[k]),
            .s  (w_s),
            .co (w_co),
            .c3 (w_c3)
        );

        assign w_c_nxt[k+1] = w_co;

        if (k < NBLK - 1) begin : g_fwd
            localparam int c_AO_NXT = opnd_off(WIDTH, k + 1);
            // Drop the four bits consumed here, pass the rest on.
            assign w_a_nxt[c_AO_NXT +: c_AW - c_BLK_W] = r_a[c_AO + c_BLK_W +: c_AW - c_BLK_W];
            assign w_b_nxt[c_AO_NXT +: c_AW - c_BLK_W] = r_b[c_AO + c_BLK_W +: c_AW - c_BLK_W];
            // Only the top block's carry into its MSB matters for overflow.
            logic w_c3_unused;
            assign w_c3_unused = w_c3;
        end else begin : g_last
            assign w_ovf_nxt = w_c3 ^ w_co;
        end

        if (k == 0) begin : g_first
            assign w_sum_nxt[c_BLK_W-1:0] = w_s;
        end else begin : g_acc
            localparam int c_SO     = sum_off(k);
            localparam int c_SO_NXT = sum_off(k + 1);
            // New block's bits go on top of the bits already produced.
            assign w_sum_nxt[c_SO_NXT +: c_BLK_W * (k + 1)] =
                {w_s, r_sum[c_SO +: c_BLK_W * k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            // Bubbles shift like data; they are never collapsed.
            r_v   <= {r_v[NBLK-1:0], in_valid};
            r_c   <= w_c_nxt;
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_sum <= w_sum_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign out_valid = r_v[NBLK];
    assign sum       = r_sum[sum_off(NBLK) +: WIDTH];
    assign cout      = r_c[NBLK];
    assign ovf       = r_ovf;

endmodule : cla_pipe_adder
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder at WIDTH 4, 16, 32.
//                All three instances share the operand/handshake inputs
//                (narrower ones see the low bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        sub;

    logic        rdy4, v4, co4, ov4;
    logic [3:0]  s4;
    logic        rdy16, v16, co16, ov16;
    logic [15:0] s16;
    logic        rdy32, v32, co32, ov32;
    logic [31:0] s32;

    int checks   = 0;
    int failures = 0;

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];

    int          wr;
    int          rd;
    logic        acc;
    logic [33:0] m;

    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .A(A[3:0]), .B(B[3:0]), .Cin(Cin), .sub(sub),
        .out_valid(v4), .out_ready(out_ready),
        .sum(s4), .cout(co4), .ovf(ov4)
    );

    cla_pipe_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .sub(sub),
        .out_valid(v16), .out_ready(out_ready),
        .sum(s16), .cout(co16), .ovf(ov16)
    );

    cla_pipe_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(v32), .out_ready(out_ready),
        .sum(s32), .cout(co32), .ovf(ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    // Returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic sb);
        logic [63:0] msk, aa, bb, full;
        logic        sa, sbb, ss, co, ov;
        msk = (64'd1 << w) - 64'd1;
        aa  = {32'd0, a} & msk;
        bb  = {32'd0, b} & msk;
        if (sb) full = aa + ((~bb) & msk) + 64'd1;
        else    full = aa + bb + {63'd0, ci};
        co  = full[w];
        sa  = aa[w-1];
        sbb = bb[w-1];
        ss  = full[w-1];
        ov  = sb ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
        return {ov, co, full[31:0] & msk[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation through all three widths; e16 = {ovf, cout, sum} hand value.
    task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic sb, input logic [17:0] e16);
        logic [33:0] e4, e32;
        e4  = model(4, a, b, ci, sb);
        e32 = model(32, a, b, ci, sb);
        A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk($sformatf("%s in_ready16", tag), rdy16, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("%s v4 c%0d", tag, c), v4, (c == 1));
            chk($sformatf("%s v16 c%0d", tag, c), v16, (c == 4));
            chk($sformatf("%s v32 c%0d", tag, c), v32, (c == 8));
            if (c == 1) chk($sformatf("%s res4", tag), {ov4, co4, s4}, {e4[33:32], e4[3:0]});
            if (c == 4) chk($sformatf("%s res16", tag), {ov16, co16, s16}, e16);
            if (c == 8) chk($sformatf("%s res32", tag), {ov32, co32, s32}, e32);
        end
    endtask

    initial begin
        va[0] = 32'h0000_1234; vb[0] = 32'h0000_4321; vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 32'hDEAD_BEEF; vb[1] = 32'h1234_5678; vc[1] = 1'b1; vs[1] = 1'b0;
        va[2] = 32'h0000_0000; vb[2] = 32'hFFFF_FFFF; vc[2] = 1'b0; vs[2] = 1'b1;
        va[3] = 32'h8000_7FFF; vb[3] = 32'h0000_0001; vc[3] = 1'b1; vs[3] = 1'b0;
        va[4] = 32'h0F0F_F0F0; vb[4] = 32'h0F0F_0F0F; vc[4] = 1'b0; vs[4] = 1'b1;
        va[5] = 32'hFFFF_8000; vb[5] = 32'h0000_8000; vc[5] = 1'b0; vs[5] = 1'b0;
        va[6] = 32'h1357_9BDF; vb[6] = 32'h2468_ACE0; vc[6] = 1'b1; vs[6] = 1'b1;
        va[7] = 32'h7FFF_FFFF; vb[7] = 32'hFFFF_FFFF; vc[7] = 1'b0; vs[7] = 1'b1;

        // ---- reset state ----
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("rst v16", v16, 0);
        chk("rst sum16", s16, 0);
        chk("rst cout16", co16, 0);
        chk("rst ovf16", ov16, 0);
        chk("rst rdy16", rdy16, 1);
        chk("rst v4", v4, 0);
        chk("rst v32", v32, 0);
        chk("rst rdy4", rdy4, 1);
        chk("rst rdy32", rdy32, 1);
        rst = 1'b0;
        tick();

        // ---- directed single operations ----
        run_single("ffff+1",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_single("5-7",        32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_single("8000-1",     32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        run_single("7fff+0+c",   32'h0000_7FFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_single("sub cin ign",32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});

        // ---- back-to-back stream, out_ready high ----
        out_ready = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c < 8) begin
                A = va[c]; B = vb[c]; Cin = vc[c]; sub = vs[c]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk($sformatf("b2b v4 c%0d", c),  v4,  (c >= 1 && c <= 8));
            chk($sformatf("b2b v16 c%0d", c), v16, (c >= 4 && c <= 11));
            chk($sformatf("b2b v32 c%0d", c), v32, (c >= 8 && c <= 15));
            if (c >= 1 && c <= 8) begin
                m = model(4, va[c-1], vb[c-1], vc[c-1], vs[c-1]);
                chk($sformatf("b2b res4 #%0d", c - 1), {ov4, co4, s4}, {m[33:32], m[3:0]});
            end
            if (c >= 4 && c <= 11) begin
                m = model(16, va[c-4], vb[c-4], vc[c-4], vs[c-4]);
                chk($sformatf("b2b res16 #%0d", c - 4), {ov16, co16, s16}, {m[33:32], m[15:0]});
            end
            if (c >= 8 && c <= 15) begin
                m = model(32, va[c-8], vb[c-8], vc[c-8], vs[c-8]);
                chk($sformatf("b2b res32 #%0d", c - 8), {ov32, co32, s32}, m);
            end
        end

        // ---- backpressure on the 16-bit instance ----
        wr = 0;
        rd = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 5 && c < 10);
            in_valid  = (wr < 8);
            if (wr < 8) begin
                A = va[wr]; B = vb[wr]; Cin = vc[wr]; sub = vs[wr];
            end
            #1;
            if (v16 && rd < 8) begin
                m = model(16, va[rd], vb[rd], vc[rd], vs[rd]);
                if (out_ready) begin
                    chk($sformatf("bp pop #%0d", rd), {ov16, co16, s16}, {m[33:32], m[15:0]});
                    rd++;
                end else begin
                    chk($sformatf("bp stall rdy c%0d", c), rdy16, 0);
                    chk($sformatf("bp held c%0d", c), {ov16, co16, s16}, {m[33:32], m[15:0]});
                end
            end else if (v16) begin
                chk("bp extra result", rd, 7);
            end
            acc = in_valid && rdy16;
            tick();
            if (acc) wr++;
        end
        chk("bp accepted", wr, 8);
        chk("bp drained", rd, 8);

        // ---- reset with results in flight ----
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = va[i]; B = vb[i]; Cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst v16", v16, 0);
        chk("mid rst sum16", s16, 0);
        chk("mid rst cout16", co16, 0);
        chk("mid rst ovf16", ov16, 0);
        chk("mid rst rdy16", rdy16, 1);
        chk("mid rst v4", v4, 0);
        chk("mid rst v32", v32, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("post rst v4 c%0d", c),  v4,  0);
            chk($sformatf("post rst v16 c%0d", c), v16, 0);
            chk($sformatf("post rst v32 c%0d", c), v32, 0);
        end

        // ---- recovery after reset ----
        run_single("post rst 5-7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cla_pipe_adder
`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into 4-bit lookahead blocks and processes one block per pipeline stage, carrying the inter-block carry in registers. Sits on the datapath wherever a full-width add/subtract is needed at clock rates a single-cycle ripple of 4-bit lookahead blocks cannot meet. Valid/ready handshake on both sides, full backpressure, 1 result per cycle sustained.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4
- NBLK (localparam), WIDTH/4, number of 4-bit blocks = pipeline depth
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode present
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+Cin, 1 = A-B
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1 (sub mode: 1 = no borrow, A >= B unsigned)
- ovf  output  1  signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1

## Operation
- Accept on the rising edge when in_valid && in_ready. Effective operands: B' = sub ? ~B : B; c0 = sub ? 1 : Cin.
- Per block: P = A^B', G = A&B'; carries c1..c4 by full lookahead (c1 = G0|P0c0, c2 = G1|P1G0|P1P0c0, c3 = ..., c4 = G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0c0); sum bits = P ^ c.
- Stage k (k = 0..NBLK-1) computes block k from its stage registers and the registered carry from stage k-1; writes sum bits [4k+3:4k], the block carry-out, and passes remaining operand bits forward. Stage 0 uses c0.
- Block carry-out is c4 of that block. Final cout = c4 of block NBLK-1; ovf = c3 XOR c4 of block NBLK-1.
- Each stage holds a valid bit; outputs are the last stage's registers.

## Timing
- Reset: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, in_ready 1. All state is reset; reset mid-operation discards every in-flight result (no partial output afterwards).
- Advance condition: adv = !out_valid || out_ready. All stages shift together when adv = 1; all hold when adv = 0. in_ready = adv (combinational from out_valid/out_ready only; no dependence on in_valid).
- Latency: operand accepted at edge T appears with out_valid = 1 after edge T+NBLK if adv stayed 1. Stall cycles add 1:1 to latency.
- Bubbles are not collapsed: an empty stage shifts as a bubble.
- Output held stable (sum, cout, ovf, out_valid) while out_valid && !out_ready.
- Simultaneous output pop and input push in the same cycle is allowed; throughput 1/cycle with out_ready tied high.
- WIDTH = 4: single stage, latency 1.
- No wrap-around state: arithmetic is modulo 2^WIDTH; cout/ovf carry the excess.

## Structure
- Shared package: block width constant (4), function or constant for NBLK, and the stage record typedef (valid, partial sum, carry, remaining operands) if the team's style uses packed structs.
- Sub-module cla_block: combinational 4-bit lookahead, inputs a[3:0], b[3:0], ci; outputs s[3:0], co, c3 (carry into bit 3, for ovf). Instantiated NBLK times by generate.
- Top holds the stage registers, sub/Cin preprocessing, and the handshake.

## Test plan
- WIDTH=16, out_ready=1: A=0xFFFF, B=0x0001, Cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0 (carry ripples through all blocks).
- WIDTH=16, sub=1: A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0, ovf=0; A=0x8000, B=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- WIDTH=16, sub=0: A=0x7FFF, B=0x0000, Cin=1 -> sum=0x8000, cout=0, ovf=1; Cin ignored in sub mode (A=B=0x1234, sub=1, Cin=1 -> sum=0x0000, cout=1).
- Back-to-back 8 random operand sets with in_valid=1, out_ready=1 -> 8 consecutive out_valid cycles, results in order, each matches reference model.
- Backpressure: fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, output stable, no loss/duplication; release -> remaining results drain in order.
- Assert rst for 1 cycle with 3 results in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale result appears later. Repeat directed cases at WIDTH=4 (latency 1) and WIDTH=32 (latency 8).
